// File: rtl/serial_pkg.sv
// serial_pkg: frame timing constants and FSM state encodings shared by the serial arbiter.
package serial_pkg;
  localparam int SFD_BITS = 8;
  localparam int CYCLES_PER_BIT = 16;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  function automatic int frame_cycles(input int width);
    return (SFD_BITS + width) * CYCLES_PER_BIT;
  endfunction
endpackage

// File: rtl/serial_arb_pick.sv
// serial_arb_pick: combinational requester picker; SERIAL_ARB_RR_EN selects round-robin, else fixed priority.
module serial_arb_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  requests,
  input  logic [IW-1:0] pointer,
  output logic          found,
  output logic [IW-1:0] index
);
  assign found = |requests;
`ifdef SERIAL_ARB_RR_EN
  logic [IW-1:0] k;
  // Descending offset so the nearest requester after the pointer wins.
  always_comb begin
    index = '0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(pointer) + i) % N);
      if (requests[k]) index = k;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^pointer;
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) if (requests[i]) index = IW'(i);
  end
`endif
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: shares one frame sender among N requesters, timing frame+gap windows itself.
// Optional SERIAL_ARB_RR_EN switches the picker from fixed priority to round-robin.
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int N = 4,
  parameter int WIDTH = 16,
  parameter int FRAME_CYCLES = frame_cycles(WIDTH),
  parameter int GAP_CYCLES = 4
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [N-1:0]         req_valid_i,
  input  logic [N*WIDTH-1:0]   req_data_i,
  output logic [N-1:0]         ack_o,
  output logic                 frame_start_o,
  output logic [WIDTH-1:0]     frame_data_o,
  output logic                 busy_o,
  output logic [$clog2(N)-1:0] grant_id_o,
  output logic                 done_o
);
  localparam int TOTAL = FRAME_CYCLES + GAP_CYCLES;
  localparam int CW = $clog2(TOTAL);
  localparam int IW = $clog2(N);
  logic [0:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] ack_q, ack_d, req_m;
  logic fs_q, fs_d, hold_q, hold_d, found, arb;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0] gid_q, gid_d, ptr_q, ptr_d, win;
  logic [WIDTH-1:0] data_a [N];
  for (genvar g = 0; g < N; g++) begin : g_data
    assign data_a[g] = req_data_i[g*WIDTH +: WIDTH];
  end
  assign arb = state_q == S_IDLE || cnt_q == '0;
  assign req_m = req_valid_i & ~ack_q;
  serial_arb_pick #(.N(N), .IW(IW)) u_pick (
    .requests(req_m),
    .pointer (ptr_q),
    .found   (found),
    .index   (win)
  );
  // hold_q marks the post-reset holdoff window, which ends without a done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ack_d = '0;
    fs_d = 1'b0;
    data_d = data_q;
    gid_d = gid_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    if (arb) begin
      hold_d = 1'b0;
      state_d = found ? S_BUSY : S_IDLE;
      if (found) begin
        cnt_d = CW'(TOTAL - 1);
        ack_d = N'(1) << win;
        fs_d = 1'b1;
        data_d = data_a[win];
        gid_d = win;
`ifdef SERIAL_ARB_RR_EN
        ptr_d = win;
`endif
      end
    end else cnt_d = cnt_q - 1'b1;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_BUSY;
      cnt_q <= CW'(TOTAL - 1);
      ack_q <= '0;
      fs_q <= 1'b0;
      data_q <= '0;
      gid_q <= '0;
      ptr_q <= IW'(N - 1);
      hold_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      fs_q <= fs_d;
      data_q <= data_d;
      gid_q <= gid_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
    end
  end
  assign ack_o = ack_q;
  assign frame_start_o = fs_q;
  assign frame_data_o = data_q;
  assign busy_o = state_q == S_BUSY;
  assign grant_id_o = gid_q;
  assign done_o = state_q == S_BUSY && cnt_q == '0 && !hold_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: randomized requesters against a cycle-count reference model with a grant scoreboard.
module tb_serial_tx_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int TOTAL = (8 + W) * 16 + 4;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [N-1:0] req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0] ack;
  logic fs, busy, done;
  logic [W-1:0] fdata;
  logic [1:0] gid;
  always #5 clk_i = ~clk_i;
  serial_tx_arbiter dut (
    .clock_i(clk_i), .reset_i(rst_i), .req_valid_i(req_valid), .req_data_i(req_data),
    .ack_o(ack), .frame_start_o(fs), .frame_data_o(fdata), .busy_o(busy),
    .grant_id_o(gid), .done_o(done)
  );
  typedef struct {int cyc; int id; logic [W-1:0] data;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  int win_end = TOTAL + 1, ptr = N - 1;
  bit holdoff = 1, rst_out = 1, exp_rst, exp_busy, exp_done, chk_en = 0;
  logic [N-1:0] m_ack, m_ack_next, hold_x;
  logic [W-1:0] last_data;
  int last_gid;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
`ifdef SERIAL_ARB_RR_EN
    for (int i = 1; i <= N; i++) if (m[(p + i) % N]) return (p + i) % N;
`else
    for (int i = 0; i < N; i++) if (m[i]) return i;
`endif
    return -1;
  endfunction

  // One clock: drive requesters for the new cycle, then advance the reference model.
  task automatic step(input bit rst, input int permille);
    int k;
    @(posedge clk_i);
    #1;
    cyc++;
    rst_i = rst;
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) begin
        if ($urandom_range(3) == 0) hold_x[i] = 1'b1;
        else req_valid[i] = 1'b0;
      end else if (hold_x[i]) begin
        req_valid[i] = 1'b0;
        hold_x[i] = 1'b0;
      end else if (!req_valid[i] && $urandom_range(999) < permille) begin
        req_valid[i] = 1'b1;
        req_data[i*W +: W] = W'($urandom);
      end
    end
    exp_rst = rst_out;
    exp_busy = cyc <= win_end;
    exp_done = cyc == win_end && !holdoff;
    m_ack = m_ack_next;
    m_ack_next = '0;
    if (rst) begin
      win_end = cyc + TOTAL;
      holdoff = 1;
      ptr = N - 1;
      rst_out = 1;
    end else begin
      rst_out = 0;
      if (cyc >= win_end) begin
        holdoff = 0;
        k = pick(req_valid & ~m_ack, ptr);
        if (k >= 0) begin
          q.push_back('{cyc + 1, k, req_data[k*W +: W]});
          m_ack_next = N'(1) << k;
          win_end = cyc + TOTAL;
          ptr = k;
        end
      end
    end
    chk_en = 1;
  endtask

  always @(negedge clk_i) if (chk_en) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_ack cyc=%0d got=none exp_id=%0d at cyc %0d", cyc, q[0].id, q[0].cyc);
      void'(q.pop_front());
    end
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    if (exp_rst) begin
      last_data = '0;
      last_gid = 0;
    end
    if (ack != '0 || fs) begin
      checks++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_grant cyc=%0d got ack=%b fs=%b exp=none", cyc, ack, fs);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack", 32'(ack), 32'(N'(1) << e.id));
        chk("frame_start", 32'(fs), 32'd1);
        chk("frame_data", 32'(fdata), 32'(e.data));
        chk("grant_id", 32'(gid), 32'(e.id));
        last_data = e.data;
        last_gid = e.id;
      end
    end else begin
      chk("data_hold", 32'(fdata), 32'(last_data));
      chk("gid_hold", 32'(gid), 32'(last_gid));
    end
  end

  initial begin
    req_valid = 4'b0001;
    req_data = '0;
    req_data[15:0] = 16'h1234;
    hold_x = '0;
    m_ack = '0;
    m_ack_next = '0;
    repeat (3) step(1, 0);
    repeat (2 * TOTAL) step(0, 0);
    repeat (6 * TOTAL) step(0, 1000);
    repeat (12 * TOTAL) step(0, 2);
    for (int r = 0; r < 3; r++) begin
      int n = 0;
      while (!(win_end - cyc == 201 && !holdoff) && n < 2000) begin
        step(0, 600);
        n++;
      end
      if (n >= 2000) begin
        checks++;
        errors++;
        $display("FAIL reset_align cyc=%0d got=timeout exp=frame window", cyc);
      end
      step(1, 600);
      if ($urandom_range(1) == 1) step(1, 600);
    end
    repeat (4 * TOTAL) step(0, 300);
    repeat (6 * TOTAL) step(0, 0);
    @(negedge clk_i);
    chk("drain_queue", 32'(q.size()), 32'd0);
    chk("drain_valid", 32'(req_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
